pipe_out_arbiter: RTL

- Round-robin arbiter that shares one outbound PipeIn-style enq channel between NREQ indication sources.
- Each winning beat is tagged with the source's method tag and loaded into a single-entry output register.
- Supports multi-beat messages: the grant is locked to one source until its beat with last=1 transfers.
- Sits on the transmit side of a portal, mirroring the receive-side tag demultiplexer.

---
 rtl/pipe_out_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_out_arbiter.sv
// Round-robin arbiter merging NREQ tagged indication sources onto one outbound enq channel.
// A source keeps the grant until its last=1 beat transfers; beats pass through a one-entry output register.
module pipe_out_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 16,
    parameter int TAG_BASE = 1,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req__ENA,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req__RDY,
    output logic                     enq__ENA,
    output logic [TAG_W-1:0]         enq_tag,
    output logic [DATA_W-1:0]        enq_data,
    output logic                     enq_last,
    input  logic                     enq__RDY,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     state_dbg
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [GW-1:0]     grant_q;
    logic              out_valid;

    logic              can_accept;
    logic              sel_ena;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;
    logic              rotate;
    logic [GW-1:0]     next_grant;
    logic [GW-1:0]     cand;
    logic              found;

    // Handshake: a beat moves on a channel only in a cycle where both __ENA and __RDY are high.
    // req__RDY is built from registered state and enq__RDY only, never from any req__ENA.
    assign can_accept = !out_valid || enq__RDY;

    always_comb begin
        sel_ena  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        req__RDY = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_ena     = req__ENA[i];
                sel_last    = req_last[i];
                sel_data    = req_data[i*DATA_W +: DATA_W];
                req__RDY[i] = can_accept;
            end
        end
    end

    assign xfer = sel_ena && can_accept;

    // Scan starts just past the current owner and visits the owner itself last.
    always_comb begin
        next_grant = grant_q;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(grant_q) + k) % NREQ);
            if (!found && req__ENA[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    // Move on after a completed message, or when the owner has nothing pending while unlocked.
    assign rotate = (state == IDLE || (xfer && sel_last)) &&
                    ((xfer && sel_last) || !sel_ena);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            grant_q   <= '0;
            out_valid <= 1'b0;
            enq_tag   <= '0;
            enq_data  <= '0;
            enq_last  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                enq_tag   <= TAG_W'(TAG_BASE) + TAG_W'(grant_q);
                enq_data  <= sel_data;
                enq_last  <= sel_last;
                state     <= sel_last ? IDLE : LOCKED;
            end else if (enq__RDY) begin
                out_valid <= 1'b0;
            end
            if (rotate) begin
                grant_q <= next_grant;
            end
        end
    end

    assign enq__ENA  = out_valid;
    assign grant_id  = grant_q;
    assign busy      = (state == LOCKED) || out_valid;
    assign state_dbg = (state == LOCKED);

endmodule
